regfile_bypass: RTL and testbench
=================================

Name: regfile_bypass

Overview:
- Parametrised register file for the pipelined core; replaces the fixed 4-entry array and single-source forwarding.
- Has NRP registered read ports, one commit write port with paired upper-half writes, a dedicated flags write port, and NFB prioritised bypass channels.
- Has a per-register pending scoreboard, so the read stage can tell when a forwarded value is still in flight.
- Sits between decode and read; the write stage drives commit, and the later stages drive the bypass channels.

Parameters:
- NR, 32, number of registers; index 0 reads as zero, NR-1 is Flags, NR-2 is PC.
- W, 32, register width in bits.
- NRP, 2, number of read ports.
- NFB, 2, number of bypass channels; channel 0 is the youngest stage.
- IW, $clog2(NR), index width.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- hold  in  1  read stage stalled; freeze read outputs
- read_index  in  NRP x IW  register requested per port
- read_value  out  NRP x W  registered read data
- read_ready  out  NRP  registered; 1 = no pending write to the indexed register
- issue_valid  in  1  an instruction targeting issue_index enters the pipe
- issue_index  in  IW  target register of the issued instruction
- issue_has_upper  in  1  issued instruction also targets issue_index+1
- write_valid  in  1  commit write
- write_index  in  IW  commit target
- write_value  in  W  commit data
- write_has_upper  in  1  also write write_upper_value to write_index+1
- write_upper_value  in  W  upper-half data
- flags_valid  in  1  write the flags register
- flags_value  in  4  CNVZ flags
- fb_valid  in  NFB  bypass channel valid
- fb_index  in  NFB x IW  bypass target
- fb_value  in  NFB x W  bypass data
- fb_has_upper  in  NFB  bypass also covers fb_index+1
- fb_upper_value  in  NFB x W  bypass upper data

Behaviour:
- Reset (asynchronous, reset_n=0): all registers 0, read_value 0, read_ready all 1, pending bits all 0. Reset during operation discards any in-flight state immediately.
- Read latency: 1 cycle. read_value[p] is registered from the resolved value of read_index[p] sampled on the same edge.
- Resolution order for register r, first match wins:
  - r == 0 returns 0.
  - Bypass channels in order 0 to NFB-1: fb_valid, then fb_index == r gives fb_value; otherwise fb_has_upper and fb_index+1 == r gives fb_upper_value.
  - Same-cycle commit: write_valid and write_index == r gives write_value; otherwise write_has_upper and write_index+1 == r gives write_upper_value.
  - Same-cycle flags port, only when r == NR-1: zero-extended flags_value.
  - Otherwise the array contents.
- Index arithmetic: index+1 is computed in IW+1 bits. An upper target at index NR would overflow; it is never matched, and the upper write is dropped without wrapping to 0.
- hold=1: read_value and read_ready keep their values. Array writes and scoreboard updates still occur.
- Commit on the clock edge:
  - write_valid writes array[write_index], then array[write_index+1] when write_has_upper and the index is in range.
  - Writes to index 0 are ignored.
  - If flags_valid and a commit to NR-1 happen in the same cycle, the flags port wins and the upper W-4 bits become 0.
- Scoreboard, one pending bit per register (bit 0 is always 0):
  - Set on issue_valid for issue_index, and for issue_index+1 when issue_has_upper.
  - Cleared on write_valid for the written indices.
  - If issue and commit hit the same register in the same cycle, set wins.
- read_ready[p] is the registered form of !pending[read_index[p]] || bypass_hit[p]. A register that a bypass channel is currently supplying counts as ready.
- PC (NR-2) is an ordinary register here; the fetch stage owns its sequencing.

Decomposition:
- Shared package:
  - regind_t and regval_t re-parametrised on IW and W
  - Flags and PC index constants
  - a bypass-channel struct {valid, index, value, has_upper, upper_value}
  - the resolve function, so the read stage and this block share the priority logic
- One sub-module, regfile_resolve: combinational lookup of a single index against the bypass channels, the commit port and the array. It is instantiated NRP times.

Test Plan:
- Reset, then read r5 on port 0 -> read_value[0]=0 and read_ready[0]=1 one cycle later.
- Commit r3=0x1234 with write_has_upper, upper=0xABCD; next cycle read r3 and r4 -> 0x1234 and 0xABCD. Commit to r31 with upper -> r31 written, no wrap into r0.
- fb0 {r7=0x11} and fb1 {r7=0x22} valid together with commit r7=0x33 -> read r7 gives 0x11. After both bypasses drop, read gives 0x33.
- Issue r9, then read r9 -> read_ready=0. Drive fb1 r9 -> ready=1 that cycle. Commit r9 -> pending cleared. Issue and commit r9 in the same cycle -> stays pending.
- Same cycle: flags_valid=0xA and commit r31=0xFFFFFFFF -> r31 reads 0x0000000A. A write to r0 leaves r0 reading 0.
- Hold=1 for 3 cycles while commit r2=5 -> read_value unchanged. After release, r2 reads 5. Assert reset_n mid-hold -> all outputs 0 and read_ready all 1 asynchronously.

Source files
------------

// File: rtl/regfile_bypass_pkg.sv
// Shared types, constants and the bypass/commit match function used by the read stage and the register file.
package regfile_bypass_pkg;

    localparam int NR_DEF = 32;
    localparam int W_DEF  = 32;
    localparam int IW_DEF = $clog2(NR_DEF);

    typedef logic [IW_DEF-1:0] regind_t;
    typedef logic [W_DEF-1:0]  regval_t;

    localparam regind_t FLAGS_IDX = regind_t'(NR_DEF - 1);
    localparam regind_t PC_IDX    = regind_t'(NR_DEF - 2);

    typedef struct packed {
        logic    valid;
        regind_t index;
        regval_t value;
        logic    has_upper;
        regval_t upper_value;
    } fb_chan_t;

    typedef struct packed {
        logic    hit;
        regval_t value;
    } lookup_t;

    // One extra bit so an upper half of the last register lands at NR and never aliases register 0.
    function automatic logic [IW_DEF:0] upper_index(regind_t idx);
        return {1'b0, idx} + 1'b1;
    endfunction

    function automatic lookup_t match_chan(fb_chan_t ch, regind_t r);
        lookup_t res;
        res.hit   = 1'b0;
        res.value = '0;
        if (ch.valid) begin
            if (ch.index == r) begin
                res.hit   = 1'b1;
                res.value = ch.value;
            end else if (ch.has_upper && (upper_index(ch.index) == {1'b0, r})) begin
                res.hit   = 1'b1;
                res.value = ch.upper_value;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_bypass_resolve.sv
// Combinational lookup of one register index against bypass channels, commit port, flags port and the array.
module regfile_bypass_resolve
    import regfile_bypass_pkg::*;
#(
    parameter int NR  = NR_DEF,
    parameter int NFB = 2
) (
    input  regind_t  index_i,
    input  fb_chan_t fb_i [NFB],
    input  fb_chan_t commit_i,
    input  logic     flags_valid_i,
    input  logic [3:0] flags_value_i,
    input  regval_t  regs_i [NR],
    output regval_t  value_o,
    output logic     fb_hit_o
);

    lookup_t commit_m;
    lookup_t fb_m;

    // Lowest-priority source is applied first; each later match overrides, so channel 0 ends up winning.
    always_comb begin
        value_o  = regs_i[index_i];
        fb_hit_o = 1'b0;
        fb_m     = '0;
        if (flags_valid_i && (index_i == FLAGS_IDX)) begin
            value_o = regval_t'(flags_value_i);
        end
        commit_m = match_chan(commit_i, index_i);
        if (commit_m.hit) begin
            value_o = commit_m.value;
        end
        for (int i = NFB - 1; i >= 0; i--) begin
            fb_m = match_chan(fb_i[i], index_i);
            if (fb_m.hit) begin
                value_o  = fb_m.value;
                fb_hit_o = 1'b1;
            end
        end
        if (index_i == '0) begin
            value_o = '0;
        end
    end

endmodule

// File: rtl/regfile_bypass.sv
// Register file with registered read ports, commit/flags write ports, prioritised bypass and a pending scoreboard.
module regfile_bypass
    import regfile_bypass_pkg::*;
#(
    parameter int NR  = NR_DEF,
    parameter int W   = W_DEF,
    parameter int NRP = 2,
    parameter int NFB = 2,
    parameter int IW  = $clog2(NR)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     hold,
    input  logic [NRP-1:0][IW-1:0]   read_index,
    output logic [NRP-1:0][W-1:0]    read_value,
    output logic [NRP-1:0]           read_ready,
    input  logic                     issue_valid,
    input  logic [IW-1:0]            issue_index,
    input  logic                     issue_has_upper,
    input  logic                     write_valid,
    input  logic [IW-1:0]            write_index,
    input  logic [W-1:0]             write_value,
    input  logic                     write_has_upper,
    input  logic [W-1:0]             write_upper_value,
    input  logic                     flags_valid,
    input  logic [3:0]               flags_value,
    input  logic [NFB-1:0]           fb_valid,
    input  logic [NFB-1:0][IW-1:0]   fb_index,
    input  logic [NFB-1:0][W-1:0]    fb_value,
    input  logic [NFB-1:0]           fb_has_upper,
    input  logic [NFB-1:0][W-1:0]    fb_upper_value
);

    // All *_valid inputs are single-cycle qualifiers with no backpressure; read_ready is a status bit, not a handshake.
    regval_t              regs_q [NR];
    regval_t              regs_d [NR];
    logic [NR-1:0]        pending_q, pending_d;
    logic [NRP-1:0][W-1:0] read_value_q, read_value_d;
    logic [NRP-1:0]       read_ready_q, read_ready_d;

    fb_chan_t             fb_ch [NFB];
    fb_chan_t             commit_ch;
    regval_t              res_value [NRP];
    logic [NRP-1:0]       res_hit;
    logic [IW_DEF:0]      up_w, up_i;

    always_comb begin
        for (int i = 0; i < NFB; i++) begin
            fb_ch[i].valid       = fb_valid[i];
            fb_ch[i].index       = fb_index[i];
            fb_ch[i].value       = fb_value[i];
            fb_ch[i].has_upper   = fb_has_upper[i];
            fb_ch[i].upper_value = fb_upper_value[i];
        end
        commit_ch.valid       = write_valid;
        commit_ch.index       = write_index;
        commit_ch.value       = write_value;
        commit_ch.has_upper   = write_has_upper;
        commit_ch.upper_value = write_upper_value;
    end

    for (genvar p = 0; p < NRP; p++) begin : g_port
        regfile_bypass_resolve #(.NR(NR), .NFB(NFB)) u_resolve (
            .index_i       (read_index[p]),
            .fb_i          (fb_ch),
            .commit_i      (commit_ch),
            .flags_valid_i (flags_valid),
            .flags_value_i (flags_value),
            .regs_i        (regs_q),
            .value_o       (res_value[p]),
            .fb_hit_o      (res_hit[p])
        );
    end

    // Issue is applied after commit so a same-cycle issue keeps the register pending.
    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        up_w      = upper_index(write_index);
        up_i      = upper_index(issue_index);
        if (write_valid) begin
            regs_d[write_index]    = write_value;
            pending_d[write_index] = 1'b0;
            if (write_has_upper && !up_w[IW_DEF]) begin
                regs_d[up_w[IW_DEF-1:0]]    = write_upper_value;
                pending_d[up_w[IW_DEF-1:0]] = 1'b0;
            end
        end
        if (flags_valid) begin
            regs_d[FLAGS_IDX] = regval_t'(flags_value);
        end
        if (issue_valid) begin
            pending_d[issue_index] = 1'b1;
            if (issue_has_upper && !up_i[IW_DEF]) begin
                pending_d[up_i[IW_DEF-1:0]] = 1'b1;
            end
        end
        regs_d[0]    = '0;
        pending_d[0] = 1'b0;
    end

    always_comb begin
        read_value_d = read_value_q;
        read_ready_d = read_ready_q;
        if (!hold) begin
            for (int p = 0; p < NRP; p++) begin
                read_value_d[p] = res_value[p];
                read_ready_d[p] = !pending_q[read_index[p]] || res_hit[p];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regs_q       <= '{default: '0};
            pending_q    <= '0;
            read_value_q <= '0;
            read_ready_q <= '1;
        end else begin
            regs_q       <= regs_d;
            pending_q    <= pending_d;
            read_value_q <= read_value_d;
            read_ready_q <= read_ready_d;
        end
    end

    assign read_value = read_value_q;
    assign read_ready = read_ready_q;

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench for regfile_bypass: reset, commit/upper, bypass priority, scoreboard, flags, hold and async reset.
module tb_regfile_bypass;

    logic                clock = 1'b0;
    logic                reset_n;
    logic                hold;
    logic [1:0][4:0]     read_index;
    logic [1:0][31:0]    read_value;
    logic [1:0]          read_ready;
    logic                issue_valid;
    logic [4:0]          issue_index;
    logic                issue_has_upper;
    logic                write_valid;
    logic [4:0]          write_index;
    logic [31:0]         write_value;
    logic                write_has_upper;
    logic [31:0]         write_upper_value;
    logic                flags_valid;
    logic [3:0]          flags_value;
    logic [1:0]          fb_valid;
    logic [1:0][4:0]     fb_index;
    logic [1:0][31:0]    fb_value;
    logic [1:0]          fb_has_upper;
    logic [1:0][31:0]    fb_upper_value;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    regfile_bypass dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .hold              (hold),
        .read_index        (read_index),
        .read_value        (read_value),
        .read_ready        (read_ready),
        .issue_valid       (issue_valid),
        .issue_index       (issue_index),
        .issue_has_upper   (issue_has_upper),
        .write_valid       (write_valid),
        .write_index       (write_index),
        .write_value       (write_value),
        .write_has_upper   (write_has_upper),
        .write_upper_value (write_upper_value),
        .flags_valid       (flags_valid),
        .flags_value       (flags_value),
        .fb_valid          (fb_valid),
        .fb_index          (fb_index),
        .fb_value          (fb_value),
        .fb_has_upper      (fb_has_upper),
        .fb_upper_value    (fb_upper_value)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_index = '0; issue_has_upper = 1'b0;
        write_valid = 1'b0; write_index = '0; write_value = '0;
        write_has_upper = 1'b0; write_upper_value = '0;
        flags_valid = 1'b0; flags_value = '0;
        fb_valid = '0; fb_index = '0; fb_value = '0;
        fb_has_upper = '0; fb_upper_value = '0;
    endtask

    task automatic commit(input logic [4:0] idx, input logic [31:0] val,
                          input logic up, input logic [31:0] upval);
        write_valid = 1'b1; write_index = idx; write_value = val;
        write_has_upper = up; write_upper_value = upval;
    endtask

    initial begin
        reset_n = 1'b0;
        hold = 1'b0;
        read_index = '0;
        idle_inputs();
        #12;
        check("reset_value0", read_value[0], 32'h0);
        check("reset_ready", {30'h0, read_ready}, 32'h3);
        reset_n = 1'b1;

        read_index[0] = 5'd5;
        tick();
        check("read_r5_value", read_value[0], 32'h0);
        check("read_r5_ready", {31'h0, read_ready[0]}, 32'h1);

        commit(5'd3, 32'h1234, 1'b1, 32'hABCD);
        tick();
        idle_inputs();
        read_index[0] = 5'd3; read_index[1] = 5'd4;
        tick();
        check("commit_r3", read_value[0], 32'h1234);
        check("commit_upper_r4", read_value[1], 32'hABCD);

        commit(5'd31, 32'h5555, 1'b1, 32'h7777);
        tick();
        idle_inputs();
        read_index[0] = 5'd31; read_index[1] = 5'd0;
        tick();
        check("commit_r31", read_value[0], 32'h5555);
        check("no_wrap_r0", read_value[1], 32'h0);

        fb_valid = 2'b11;
        fb_index[0] = 5'd7; fb_value[0] = 32'h11;
        fb_index[1] = 5'd7; fb_value[1] = 32'h22;
        fb_has_upper[1] = 1'b1; fb_upper_value[1] = 32'h88;
        commit(5'd7, 32'h33, 1'b0, 32'h0);
        read_index[0] = 5'd7; read_index[1] = 5'd8;
        tick();
        check("fb0_priority", read_value[0], 32'h11);
        check("fb1_upper", read_value[1], 32'h88);
        idle_inputs();
        tick();
        check("after_fb_r7", read_value[0], 32'h33);

        issue_valid = 1'b1; issue_index = 5'd9;
        tick();
        issue_index = 5'd10; issue_has_upper = 1'b1;
        tick();
        idle_inputs();
        read_index[0] = 5'd9; read_index[1] = 5'd11;
        tick();
        check("pending_r9", {31'h0, read_ready[0]}, 32'h0);
        check("pending_r11_upper", {31'h0, read_ready[1]}, 32'h0);
        fb_valid[1] = 1'b1; fb_index[1] = 5'd9; fb_value[1] = 32'h99;
        tick();
        check("fb_ready_r9", {31'h0, read_ready[0]}, 32'h1);
        check("fb_value_r9", read_value[0], 32'h99);
        idle_inputs();
        commit(5'd9, 32'h90, 1'b0, 32'h0);
        tick();
        check("commit_fwd_r9", read_value[0], 32'h90);
        check("commit_not_ready_r9", {31'h0, read_ready[0]}, 32'h0);
        idle_inputs();
        tick();
        check("cleared_r9", {31'h0, read_ready[0]}, 32'h1);
        commit(5'd9, 32'h91, 1'b0, 32'h0);
        issue_valid = 1'b1; issue_index = 5'd9;
        tick();
        idle_inputs();
        tick();
        check("issue_beats_commit", {31'h0, read_ready[0]}, 32'h0);

        flags_valid = 1'b1; flags_value = 4'hA;
        commit(5'd31, 32'hFFFF_FFFF, 1'b0, 32'h0);
        read_index[0] = 5'd31;
        tick();
        check("commit_fwd_over_flags", read_value[0], 32'hFFFF_FFFF);
        idle_inputs();
        tick();
        check("flags_wins_array", read_value[0], 32'h0000_000A);
        commit(5'd0, 32'h1234, 1'b0, 32'h0);
        read_index[0] = 5'd0;
        tick();
        idle_inputs();
        tick();
        check("r0_stays_zero", read_value[0], 32'h0);

        read_index[0] = 5'd2; read_index[1] = 5'd11;
        tick();
        check("pre_hold_r2", read_value[0], 32'h0);
        hold = 1'b1;
        commit(5'd2, 32'h5, 1'b0, 32'h0);
        read_index[0] = 5'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            idle_inputs();
            check("hold_frozen", read_value[0], 32'h0);
        end
        hold = 1'b0;
        read_index[0] = 5'd2;
        tick();
        check("post_hold_r2", read_value[0], 32'h5);
        check("post_hold_r11_pending", {31'h0, read_ready[1]}, 32'h0);
        hold = 1'b1;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_value0", read_value[0], 32'h0);
        check("async_reset_ready", {30'h0, read_ready}, 32'h3);
        #1;
        reset_n = 1'b1;
        hold = 1'b0;
        tick();
        check("reset_clears_r2", read_value[0], 32'h0);
        check("reset_clears_pending", {31'h0, read_ready[1]}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
